// File: rtl/pmc_bus_initiator.sv
// Single-outstanding req/gnt/rvalid bus initiator toward the PMC register file.
// Accepts one local command at a time and returns read data or an error response.
module pmc_bus_initiator #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_we,
    input  logic [15:0] i_cmd_offset,
    input  logic [31:0] i_cmd_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_req,
    output logic [31:0] o_addr,
    output logic        o_we,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic        i_gnt,
    input  logic        i_rvalid,
    input  logic [31:0] i_rdata,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RSP    = 2'd3
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_misaligned;
    logic        w_expired;
    logic [7:0]  w_cnt_inc;

    assign w_misaligned = (i_cmd_offset[1:0] != 2'b00);
    assign w_expired    = (r_cnt >= TO_LAST);
    // Saturating increment so a stuck counter never wraps back into range
    assign w_cnt_inc    = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    w_next = w_misaligned ? ST_RSP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_gnt) begin
                    w_next = ST_WAIT_R;
                end else if (w_expired) begin
                    w_next = ST_RSP;
                end
            end
            ST_WAIT_R: begin
                if (i_rvalid || w_expired) begin
                    w_next = ST_RSP;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_cmd_ready = 1'b0;
        o_req       = 1'b0;
        o_be        = 4'h0;
        o_rsp_valid = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                o_busy      = 1'b0;
            end
            ST_REQ: begin
                o_req = 1'b1;
                o_be  = 4'hF;
            end
            ST_RSP:  o_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Bus fields are only reloaded by aligned commands, so misaligned ones leave the bus untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 8'd0;
            r_addr  <= 32'd0;
            r_we    <= 1'b0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_cnt   <= 8'd0;
                        r_rdata <= 32'd0;
                        r_err   <= w_misaligned;
                        if (!w_misaligned) begin
                            r_addr  <= {BASE_ADDR[31:16], i_cmd_offset};
                            r_we    <= i_cmd_we;
                            r_wdata <= i_cmd_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (i_gnt) begin
                        r_cnt <= 8'd0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_expired) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_WAIT_R: begin
                    if (i_rvalid) begin
                        r_rdata <= r_we ? 32'd0 : i_rdata;
                        r_err   <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_expired) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_addr      = r_addr;
    assign o_we        = r_we;
    assign o_wdata     = r_wdata;
    assign o_rsp_rdata = r_rdata;
    assign o_rsp_err   = r_err;

endmodule

// File: tb/tb_pmc_bus_initiator.sv
// Bench for pmc_bus_initiator: directed scenarios plus randomized transactions
// checked against a cycle-count model derived from the transaction rules.
module tb_pmc_bus_initiator;

    localparam logic [31:0] BASE = 32'h4001_0000;
    localparam int          TO   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [15:0] cmd_offset;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        req, we, gnt, rvalid, busy;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;

    int n_tests = 0;
    int n_fail  = 0;

    // observations of the last transaction
    int          ob_req_cycles, ob_first_req, ob_rsp_cyc, ob_wait;
    logic [31:0] ob_rdata;
    logic        ob_err, ob_bus_bad, ob_be_bad, ob_unstable, ob_ready_seen, ob_busy_bad, ob_hung;
    // model expectations
    int          ex_req_cycles, ex_rsp_cyc;
    logic [31:0] ex_rdata;
    logic        ex_err;

    always #5 clk = ~clk;

    pmc_bus_initiator #(.BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
        .i_cmd_offset(cmd_offset), .i_cmd_wdata(cmd_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_req(req), .o_addr(addr), .o_we(we), .o_be(be), .o_wdata(wdata),
        .i_gnt(gnt), .i_rvalid(rvalid), .i_rdata(rdata), .o_busy(busy)
    );

    // Transaction-level reference: cycles are counted from the acceptance edge (cycle 0)
    task automatic model(input logic m_we, input logic [15:0] off, input int gdly, input int rdly,
                         input logic [31:0] rd);
        int g;
        ex_rdata = 32'd0;
        if (off[1:0] != 2'b00) begin
            ex_req_cycles = 0; ex_rsp_cyc = 1; ex_err = 1'b1;
        end else if (gdly >= TO) begin
            ex_req_cycles = TO; ex_rsp_cyc = TO + 1; ex_err = 1'b1;
        end else begin
            ex_req_cycles = gdly + 1;
            g = gdly + 1;
            if (rdly >= TO) begin
                ex_rsp_cyc = g + 1 + TO; ex_err = 1'b1;
            end else begin
                ex_rsp_cyc = g + 2 + rdly; ex_err = 1'b0;
                ex_rdata   = m_we ? 32'd0 : rd;
            end
        end
    endtask

    task automatic run_txn(input logic t_we, input logic [15:0] off, input logic [31:0] wd,
                           input int gdly, input int rdly, input logic [31:0] rd, input int rdy_dly,
                           input int stray_cyc, input logic noise, input logic hold_next,
                           input logic [15:0] next_off);
        int          g, reqs;
        logic        got_rsp, done;
        logic [31:0] exp_addr;
        exp_addr = {BASE[31:16], off};
        ob_req_cycles = 0; ob_first_req = -1; ob_rsp_cyc = -1; ob_wait = 0;
        ob_rdata = 32'd0; ob_err = 1'b0; ob_bus_bad = 1'b0; ob_be_bad = 1'b0; ob_unstable = 1'b0;
        ob_ready_seen = 1'b0; ob_busy_bad = 1'b0; ob_hung = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        while (!cmd_ready && ob_wait < 50) begin
            ob_wait++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            ob_hung = 1'b1;
            return;
        end
        cmd_valid = 1'b1; cmd_we = t_we; cmd_offset = off; cmd_wdata = wd;
        g = -1; reqs = 0; got_rsp = 1'b0; done = 1'b0;
        for (int k = 1; k <= 600 && !done; k++) begin
            @(negedge clk);
            if (hold_next) begin
                cmd_valid = 1'b1; cmd_we = 1'b0; cmd_offset = next_off; cmd_wdata = ~wd;
            end else begin
                cmd_valid = 1'b0;
            end
            if (cmd_ready) ob_ready_seen = 1'b1;
            if (!busy) ob_busy_bad = 1'b1;
            if (req) begin
                reqs++;
                if (ob_first_req < 0) ob_first_req = k;
                if (addr !== exp_addr || we !== t_we || wdata !== wd || be !== 4'hF) ob_bus_bad = 1'b1;
            end else begin
                if (be !== 4'h0) ob_be_bad = 1'b1;
                if (reqs > 0 && (addr !== exp_addr || we !== t_we || wdata !== wd)) ob_bus_bad = 1'b1;
            end
            gnt = 1'b0; rvalid = 1'b0;
            if (req && g < 0 && reqs - 1 == gdly) begin
                gnt = 1'b1; g = k;
            end else if (!req && noise) begin
                gnt = 1'($urandom_range(0, 1));
            end
            if (g > 0 && k == g + 1 + rdly) begin
                rvalid = 1'b1; rdata = rd;
            end else begin
                rdata = $urandom;
                if (k == stray_cyc) rvalid = 1'b1;
            end
            if (rsp_valid) begin
                if (!got_rsp) begin
                    got_rsp = 1'b1; ob_rsp_cyc = k; ob_rdata = rsp_rdata; ob_err = rsp_err;
                end else if (rsp_rdata !== ob_rdata || rsp_err !== ob_err) begin
                    ob_unstable = 1'b1;
                end
                if (k >= ob_rsp_cyc + rdy_dly) begin
                    rsp_ready = 1'b1; done = 1'b1;
                end
            end else begin
                rsp_ready = 1'b0;
            end
        end
        ob_req_cycles = reqs;
        if (!done) ob_hung = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({req, we, be, addr, wdata, rsp_valid, rsp_rdata, rsp_err, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b we=%b be=%h addr=%h wdata=%h rsp_valid=%b rdata=%h err=%b busy=%b, all required 0",
                     req, we, be, addr, wdata, rsp_valid, rsp_rdata, rsp_err, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_write_basic();
        run_txn(1'b1, 16'h0000, 32'h0000_00A5, 0, 0, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, 16'h0);
        model(1'b1, 16'h0000, 0, 0, 32'hFFFF_FFFF);
        n_tests++;
        if (ob_req_cycles !== 1 || ob_first_req !== 1) begin
            n_fail++; $display("FAIL wr_req: cycles=%0d first=%0d expected 1/1", ob_req_cycles, ob_first_req);
        end
        n_tests++;
        if (ob_bus_bad !== 1'b0 || ob_be_bad !== 1'b0) begin
            n_fail++; $display("FAIL wr_bus: bus_bad=%b be_bad=%b expected 0/0", ob_bus_bad, ob_be_bad);
        end
        n_tests++;
        if (ob_rsp_cyc !== 3 || ob_rsp_cyc !== ex_rsp_cyc) begin
            n_fail++; $display("FAIL wr_rsp_cyc: got %0d expected 3", ob_rsp_cyc);
        end
        n_tests++;
        if (ob_err !== 1'b0 || ob_rdata !== 32'd0) begin
            n_fail++; $display("FAIL wr_rsp: err=%b rdata=%h expected 0/00000000", ob_err, ob_rdata);
        end
    endtask

    task automatic test_read_delayed();
        run_txn(1'b0, 16'h0004, 32'h1111_2222, 3, 0, 32'hDEAD_BEEF, 1, 0, 1'b0, 1'b0, 16'h0);
        model(1'b0, 16'h0004, 3, 0, 32'hDEAD_BEEF);
        n_tests++;
        if (ob_req_cycles !== 4 || ob_bus_bad !== 1'b0) begin
            n_fail++; $display("FAIL rd_req: cycles=%0d bus_bad=%b expected 4/0", ob_req_cycles, ob_bus_bad);
        end
        n_tests++;
        if (ob_rdata !== 32'hDEAD_BEEF || ob_err !== 1'b0 || ob_unstable !== 1'b0) begin
            n_fail++; $display("FAIL rd_rsp: rdata=%h err=%b unstable=%b expected deadbeef/0/0", ob_rdata, ob_err, ob_unstable);
        end
        n_tests++;
        if (ob_rsp_cyc !== ex_rsp_cyc) begin
            n_fail++; $display("FAIL rd_rsp_cyc: got %0d expected %0d", ob_rsp_cyc, ex_rsp_cyc);
        end
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 16'h00FC, 32'h0, 255, 0, 32'h0BAD_0BAD, 3, TO + 3, 1'b0, 1'b0, 16'h0);
        n_tests++;
        if (ob_req_cycles !== TO || ob_first_req !== 1) begin
            n_fail++; $display("FAIL to_req: cycles=%0d first=%0d expected %0d/1", ob_req_cycles, ob_first_req, TO);
        end
        n_tests++;
        if (ob_rsp_cyc !== TO + 1) begin
            n_fail++; $display("FAIL to_rsp_cyc: got %0d expected %0d", ob_rsp_cyc, TO + 1);
        end
        n_tests++;
        if (ob_err !== 1'b1 || ob_rdata !== 32'd0 || ob_unstable !== 1'b0) begin
            n_fail++; $display("FAIL to_rsp: err=%b rdata=%h unstable=%b expected 1/00000000/0", ob_err, ob_rdata, ob_unstable);
        end
    endtask

    task automatic test_misaligned();
        run_txn(1'b1, 16'h0002, 32'h5555_AAAA, 0, 0, 32'h0, 0, 0, 1'b0, 1'b0, 16'h0);
        n_tests++;
        if (ob_req_cycles !== 0 || ob_be_bad !== 1'b0) begin
            n_fail++; $display("FAIL mis_req: cycles=%0d be_bad=%b expected 0/0", ob_req_cycles, ob_be_bad);
        end
        n_tests++;
        if (ob_rsp_cyc !== 1 || ob_err !== 1'b1 || ob_rdata !== 32'd0) begin
            n_fail++; $display("FAIL mis_rsp: cyc=%0d err=%b rdata=%h expected 1/1/00000000", ob_rsp_cyc, ob_err, ob_rdata);
        end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 16'h0010, 32'hCAFE_0001, 0, 1, 32'h0123_4567, 5, 0, 1'b0, 1'b1, 16'h0020);
        n_tests++;
        if (ob_ready_seen !== 1'b0 || ob_unstable !== 1'b0 || ob_rdata !== 32'h0123_4567) begin
            n_fail++; $display("FAIL b2b_hold: ready_seen=%b unstable=%b rdata=%h expected 0/0/01234567",
                               ob_ready_seen, ob_unstable, ob_rdata);
        end
        run_txn(1'b0, 16'h0020, ~32'hCAFE_0001, 2, 0, 32'h89AB_CDEF, 0, 0, 1'b0, 1'b0, 16'h0);
        n_tests++;
        if (ob_wait !== 0 || ob_bus_bad !== 1'b0 || ob_req_cycles !== 3) begin
            n_fail++; $display("FAIL b2b_second: wait=%0d bus_bad=%b req_cycles=%0d expected 0/0/3",
                               ob_wait, ob_bus_bad, ob_req_cycles);
        end
        n_tests++;
        if (ob_rdata !== 32'h89AB_CDEF || ob_err !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second_rsp: rdata=%h err=%b expected 89abcdef/0", ob_rdata, ob_err);
        end
    endtask

    task automatic test_reset_midway();
        logic bad;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_offset = 16'h0008; cmd_wdata = 32'h7777_7777;
        gnt = 1'b0; rvalid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_tests++;
        if (req !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_req: got %b expected 1", req);
        end
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || req !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_waitr: busy=%b req=%b expected 1/0", busy, req);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678;
        n_tests++;
        if ({req, we, be, addr, wdata, rsp_valid, rsp_rdata, rsp_err, busy} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: req=%b we=%b be=%h addr=%h wdata=%h rsp_valid=%b rdata=%h err=%b busy=%b, all required 0",
                     req, we, be, addr, wdata, rsp_valid, rsp_rdata, rsp_err, busy);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rvalid = 1'b0;
            if (rsp_valid !== 1'b0 || busy !== 1'b0 || req !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_quiet: activity seen=%b expected 0", bad);
        end
        run_txn(1'b1, 16'h000C, 32'hA5A5_5A5A, 1, 2, 32'h0, 0, 0, 1'b0, 1'b0, 16'h0);
        model(1'b1, 16'h000C, 1, 2, 32'h0);
        n_tests++;
        if (ob_rsp_cyc !== ex_rsp_cyc || ob_err !== 1'b0 || ob_bus_bad !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_next: cyc=%0d err=%b bus_bad=%b expected %0d/0/0",
                               ob_rsp_cyc, ob_err, ob_bus_bad, ex_rsp_cyc);
        end
    endtask

    task automatic test_random();
        logic        r_we;
        logic [15:0] off;
        logic [31:0] wd, rd;
        int          gdly, rdly, rdy;
        for (int it = 0; it < 25; it++) begin
            r_we = 1'($urandom_range(0, 1));
            off  = 16'($urandom) & 16'hFFFC;
            if ($urandom_range(0, 7) == 0) off[1:0] = 2'($urandom_range(1, 3));
            wd   = $urandom;
            rd   = $urandom;
            gdly = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 5));
            rdly = ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 3));
            rdy  = int'($urandom_range(0, 3));
            run_txn(r_we, off, wd, gdly, rdly, rd, rdy, 0, 1'b1, 1'b0, 16'h0);
            model(r_we, off, gdly, rdly, rd);
            n_tests++;
            if (ob_hung !== 1'b0 || ob_req_cycles !== ex_req_cycles || ob_rsp_cyc !== ex_rsp_cyc) begin
                n_fail++; $display("FAIL rand_timing[%0d]: hung=%b req=%0d rsp_cyc=%0d expected 0/%0d/%0d",
                                   it, ob_hung, ob_req_cycles, ob_rsp_cyc, ex_req_cycles, ex_rsp_cyc);
            end
            n_tests++;
            if (ob_err !== ex_err || ob_rdata !== ex_rdata) begin
                n_fail++; $display("FAIL rand_rsp[%0d]: err=%b rdata=%h expected %b/%h", it, ob_err, ob_rdata, ex_err, ex_rdata);
            end
            n_tests++;
            if (ob_bus_bad !== 1'b0 || ob_be_bad !== 1'b0 || ob_unstable !== 1'b0 || ob_busy_bad !== 1'b0) begin
                n_fail++; $display("FAIL rand_bus[%0d]: bus_bad=%b be_bad=%b unstable=%b busy_bad=%b expected all 0",
                                   it, ob_bus_bad, ob_be_bad, ob_unstable, ob_busy_bad);
            end
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_offset = 16'h0; cmd_wdata = 32'h0;
        rsp_ready = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        test_reset();
        test_write_basic();
        test_read_delayed();
        test_timeout();
        test_misaligned();
        test_back_to_back();
        test_reset_midway();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
